// File: rtl/mem_port_arbiter.sv
// Shares the single data-memory port between instruction fetch and the load/store unit.
// One transaction at a time: latch in IDLE, present in ISSUE, await response (with timeout) in WAIT.
module mem_port_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [XLEN-1:0] ifu_addr,
    output logic            ifu_resp_valid,
    output logic [XLEN-1:0] ifu_rdata,
    output logic            ifu_err,
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [XLEN-1:0] lsu_addr,
    input  logic            lsu_wen,
    input  logic [XLEN-1:0] lsu_wdata,
    input  logic [3:0]      lsu_wmask,
    output logic            lsu_resp_valid,
    output logic [XLEN-1:0] lsu_rdata,
    output logic            lsu_err,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wmask,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state_reg, state_next;
    logic            ptr_lsu_reg, ptr_lsu_next;   // 1: LSU wins a tie
    logic            own_lsu_reg, own_lsu_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [XLEN-1:0] addr_reg, addr_next;
    logic [XLEN-1:0] wdata_reg, wdata_next;
    logic            wen_reg, wen_next;
    logic [3:0]      wmask_reg, wmask_next;
    logic            ifu_rv_reg, ifu_rv_next, ifu_err_reg, ifu_err_next;
    logic            lsu_rv_reg, lsu_rv_next, lsu_err_reg, lsu_err_next;
    logic [XLEN-1:0] ifu_rdata_reg, ifu_rdata_next, lsu_rdata_reg, lsu_rdata_next;
    logic            grant_ifu, grant_lsu;
    logic            done;
    logic [XLEN-1:0] done_rdata;

    // Readies are held low while reset is asserted so every output reads 0 in reset.
    assign grant_lsu = (state_reg == IDLE) && rst && lsu_req_valid
                       && (!ifu_req_valid || ptr_lsu_reg);
    assign grant_ifu = (state_reg == IDLE) && rst && ifu_req_valid
                       && (!lsu_req_valid || !ptr_lsu_reg);

    assign ifu_req_ready  = grant_ifu;
    assign lsu_req_ready  = grant_lsu;
    assign mem_req_valid  = (state_reg == ISSUE);
    assign mem_addr       = addr_reg;
    assign mem_wen        = wen_reg;
    assign mem_wdata      = wdata_reg;
    assign mem_wmask      = wmask_reg;
    assign ifu_resp_valid = ifu_rv_reg;
    assign ifu_rdata      = ifu_rdata_reg;
    assign ifu_err        = ifu_err_reg;
    assign lsu_resp_valid = lsu_rv_reg;
    assign lsu_rdata      = lsu_rdata_reg;
    assign lsu_err        = lsu_err_reg;

    // A real response wins over a timeout landing in the same cycle.
    assign done       = (state_reg == WAIT) && (mem_resp_valid || (cnt_reg >= CNT_LAST));
    assign done_rdata = (mem_resp_valid && !wen_reg) ? mem_rdata : '0;

    always_comb begin
        state_next     = state_reg;
        ptr_lsu_next   = ptr_lsu_reg;
        own_lsu_next   = own_lsu_reg;
        cnt_next       = cnt_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        wen_next       = wen_reg;
        wmask_next     = wmask_reg;
        ifu_rv_next    = 1'b0;
        ifu_err_next   = 1'b0;
        ifu_rdata_next = '0;
        lsu_rv_next    = 1'b0;
        lsu_err_next   = 1'b0;
        lsu_rdata_next = '0;

        case (state_reg)
            IDLE: begin
                if (grant_lsu) begin
                    own_lsu_next = 1'b1;
                    addr_next    = lsu_addr;
                    wen_next     = lsu_wen;
                    wdata_next   = lsu_wdata;
                    wmask_next   = lsu_wen ? lsu_wmask : 4'b0000;
                    state_next   = ISSUE;
                end else if (grant_ifu) begin
                    own_lsu_next = 1'b0;
                    addr_next    = ifu_addr;
                    wen_next     = 1'b0;
                    wdata_next   = '0;
                    wmask_next   = 4'b0000;
                    state_next   = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    cnt_next   = '0;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg != {CW{1'b1}}) begin
                    cnt_next = cnt_reg + 1'b1;
                end
                if (done) begin
                    if (own_lsu_reg) begin
                        lsu_rv_next    = 1'b1;
                        lsu_err_next   = !mem_resp_valid;
                        lsu_rdata_next = done_rdata;
                    end else begin
                        ifu_rv_next    = 1'b1;
                        ifu_err_next   = !mem_resp_valid;
                        ifu_rdata_next = mem_resp_valid ? mem_rdata : '0;
                    end
                    ptr_lsu_next = !own_lsu_reg;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            ptr_lsu_reg   <= 1'b1;
            own_lsu_reg   <= 1'b0;
            cnt_reg       <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wen_reg       <= 1'b0;
            wmask_reg     <= 4'b0000;
            ifu_rv_reg    <= 1'b0;
            ifu_err_reg   <= 1'b0;
            ifu_rdata_reg <= '0;
            lsu_rv_reg    <= 1'b0;
            lsu_err_reg   <= 1'b0;
            lsu_rdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            ptr_lsu_reg   <= ptr_lsu_next;
            own_lsu_reg   <= own_lsu_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            wen_reg       <= wen_next;
            wmask_reg     <= wmask_next;
            ifu_rv_reg    <= ifu_rv_next;
            ifu_err_reg   <= ifu_err_next;
            ifu_rdata_reg <= ifu_rdata_next;
            lsu_rv_reg    <= lsu_rv_next;
            lsu_err_reg   <= lsu_err_next;
            lsu_rdata_reg <= lsu_rdata_next;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter (TIMEOUT=4): reset/grant table, directed corner sequences,
// then random traffic checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int XLEN = 32;
    localparam int T    = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_err;
    logic [XLEN-1:0] ifu_addr, ifu_rdata;
    logic            lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_err;
    logic [XLEN-1:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]      lsu_wmask;
    logic            mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]      mem_wmask;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge, outputs sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_req_valid = 0; ifu_addr = '0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, {mem_req_valid, mem_wen, mem_wmask, ifu_req_ready, lsu_req_ready,
                            ifu_resp_valid, ifu_err, lsu_resp_valid, lsu_err}, 64'h0);
        chk({tag, "_mem_addr"}, mem_addr, 64'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 64'h0);
        chk({tag, "_ifu_rdata"}, ifu_rdata, 64'h0);
        chk({tag, "_lsu_rdata"}, lsu_rdata, 64'h0);
    endtask

    typedef struct {
        logic iv;
        logic lv;
        logic exp_ir;
        logic exp_lr;
    } gvec_t;

    // Random-phase model: one outstanding transaction described by timestamps.
    bit              t_live, t_acc, t_own, t_wen, ptr_lsu, exp_pulse, exp_mrv, g_i, g_l, ig, lg;
    int              t_g, t_a, t_d, t_done, cyc, ntxn;
    logic [XLEN-1:0] t_addr, t_wdata, t_rdata, exp_rd;
    logic [3:0]      t_wmask;

    initial begin
        gvec_t gv[4];
        logic  exp_l;

        // ---------- reset state and first-grant table ----------
        gv[0] = '{iv: 0, lv: 0, exp_ir: 0, exp_lr: 0};
        gv[1] = '{iv: 1, lv: 0, exp_ir: 1, exp_lr: 0};
        gv[2] = '{iv: 0, lv: 1, exp_ir: 0, exp_lr: 1};
        gv[3] = '{iv: 1, lv: 1, exp_ir: 0, exp_lr: 1};
        for (int i = 0; i < 4; i++) begin
            do_reset();
            #1 check_all_zero($sformatf("reset%0d", i));
            ifu_req_valid = gv[i].iv; lsu_req_valid = gv[i].lv;
            ifu_addr = 32'h1000 + i; lsu_addr = 32'h2000 + i;
            #1;
            chk($sformatf("tbl%0d_ifu_ready", i), ifu_req_ready, gv[i].exp_ir);
            chk($sformatf("tbl%0d_lsu_ready", i), lsu_req_ready, gv[i].exp_lr);
            $display("table vector %0d: ifu_v=%0d lsu_v=%0d -> ifu_rdy=%0d lsu_rdy=%0d",
                     i, gv[i].iv, gv[i].lv, ifu_req_ready, lsu_req_ready);
        end

        // ---------- reset in the middle of an outstanding store ----------
        do_reset();
        tick(); lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_2000;
        lsu_wdata = 32'h1111_2222; lsu_wmask = 4'hF;
        #1 chk("rstw_grant", lsu_req_ready, 1);
        tick(); lsu_req_valid = 0; mem_req_ready = 1;
        tick(); mem_req_ready = 0;                 // now waiting for the response
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        #1 rst = 1'b0;
        #1 check_all_zero("rstw_async");
        tick(); #1 check_all_zero("rstw_held");
        tick(); rst = 1'b1;
        #1;
        chk("rstw_ifu_ready", ifu_req_ready, 1);
        chk("rstw_lsu_ready", lsu_req_ready, 0);
        tick(); ifu_req_valid = 0;
        #1 chk("rstw_mem_addr", mem_addr, 32'h8000_0000);
        $display("reset-in-wait sequence done");

        // ---------- single fetch, minimum latency ----------
        do_reset();
        tick(); ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
        #1 chk("fetch_ready", ifu_req_ready, 1);
        tick(); ifu_req_valid = 0; mem_req_ready = 1;
        #1;
        chk("fetch_mem_valid", mem_req_valid, 1);
        chk("fetch_mem_addr", mem_addr, 32'h8000_0004);
        chk("fetch_mem_wen_mask", {mem_wen, mem_wmask}, 0);
        tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0000_0413;
        #1 chk("fetch_no_early", ifu_resp_valid, 0);
        tick(); mem_resp_valid = 0;
        #1;
        chk("fetch_resp_valid", ifu_resp_valid, 1);
        chk("fetch_rdata", ifu_rdata, 32'h0000_0413);
        chk("fetch_err", ifu_err, 0);
        chk("fetch_lsu_quiet", lsu_resp_valid, 0);
        tick(); #1 chk("fetch_pulse_1cyc", ifu_resp_valid, 0);
        $display("single fetch sequence done");

        // ---------- both valid: round-robin alternation ----------
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tick();
            ifu_req_valid = 1; lsu_req_valid = 1; lsu_wen = 0;
            ifu_addr = 32'h100 + k; lsu_addr = 32'h200 + k;
            mem_req_ready = 0; mem_resp_valid = 0;
            #1;
            exp_l = (k % 2 == 0);
            if (k > 0) begin
                chk($sformatf("alt%0d_prev_pulse", k), {lsu_resp_valid, ifu_resp_valid},
                    exp_l ? 2'b01 : 2'b10);
            end
            if (k < 4) begin
                chk($sformatf("alt%0d_lsu_ready", k), lsu_req_ready, exp_l);
                chk($sformatf("alt%0d_ifu_ready", k), ifu_req_ready, !exp_l);
                tick(); mem_req_ready = 1;
                #1;
                chk($sformatf("alt%0d_busy_ready", k), {ifu_req_ready, lsu_req_ready}, 0);
                chk($sformatf("alt%0d_mem_addr", k), mem_addr, exp_l ? 32'h200 + k : 32'h100 + k);
                tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = k;
                $display("alternation grant %0d -> %s", k, exp_l ? "lsu" : "ifu");
            end
        end

        // ---------- store held off by a stalled memory ----------
        do_reset();
        tick(); lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_1000;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
        #1 chk("st_ready", lsu_req_ready, 1);
        for (int s = 0; s < 6; s++) begin
            tick(); lsu_req_valid = 0; lsu_addr = 32'h0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
            mem_req_ready = (s == 5);
            #1;
            chk($sformatf("st%0d_valid", s), mem_req_valid, 1);
            chk($sformatf("st%0d_fields", s), {mem_addr, mem_wdata},
                {32'h8000_1000, 32'hDEAD_BEEF});
            chk($sformatf("st%0d_wen_mask", s), {mem_wen, mem_wmask}, 5'b10011);
        end
        tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
        tick(); mem_resp_valid = 0;
        #1;
        chk("st_resp", {lsu_resp_valid, lsu_err}, 2'b10);
        chk("st_rdata", lsu_rdata, 0);
        $display("stalled store sequence done");

        // ---------- timeout, then final-cycle response ----------
        for (int m = 0; m < 2; m++) begin
            do_reset();
            tick(); lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_3000 + m;
            #1 chk($sformatf("to%0d_ready", m), lsu_req_ready, 1);
            tick(); lsu_req_valid = 0; mem_req_ready = 1;
            for (int i = 0; i < T; i++) begin
                tick(); mem_req_ready = 0;
                mem_resp_valid = (m == 1) && (i == T - 1);
                mem_rdata = 32'hCAFE_F00D;
                #1 chk($sformatf("to%0d_quiet%0d", m, i), lsu_resp_valid, 0);
            end
            tick(); mem_resp_valid = (m == 0); mem_rdata = 32'h5555_AAAA;
            #1;
            chk($sformatf("to%0d_valid", m), lsu_resp_valid, 1);
            chk($sformatf("to%0d_err", m), lsu_err, (m == 0));
            chk($sformatf("to%0d_rdata", m), lsu_rdata, (m == 0) ? 32'h0 : 32'hCAFE_F00D);
            tick(); mem_resp_valid = 0;
            #1 chk($sformatf("to%0d_late_ignored", m), {lsu_resp_valid, ifu_resp_valid, mem_req_valid}, 0);
            $display("timeout sequence %0d done", m);
        end

        // ---------- random traffic against the transaction model ----------
        do_reset();
        t_live = 0; t_acc = 0; ptr_lsu = 1; ig = 0; lg = 0; ntxn = 0;
        for (cyc = 0; cyc < 2500; cyc++) begin
            tick();
            exp_pulse = t_live && t_acc && (cyc == t_done);
            if (exp_pulse) begin
                ptr_lsu = !t_own;
                t_live  = 0;
            end
            if (!ifu_req_valid || ig) begin
                ifu_req_valid = 1'($urandom_range(0, 1)); ifu_addr = $urandom;
            end
            if (!lsu_req_valid || lg) begin
                lsu_req_valid = 1'($urandom_range(0, 1)); lsu_addr = $urandom;
                lsu_wen = 1'($urandom_range(0, 1)); lsu_wdata = $urandom; lsu_wmask = 4'($urandom);
            end
            ig = 0; lg = 0;
            mem_req_ready = ($urandom_range(0, 2) != 0);
            if (t_live && t_acc) begin
                mem_resp_valid = (t_d < T) && (cyc == t_a + 1 + t_d);
                mem_rdata = mem_resp_valid ? t_rdata : $urandom;
            end else begin
                mem_resp_valid = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
            #1;
            chk("rnd_ifu_resp_valid", ifu_resp_valid, exp_pulse && !t_own);
            chk("rnd_lsu_resp_valid", lsu_resp_valid, exp_pulse && t_own);
            if (exp_pulse) begin
                exp_rd = (t_d >= T || (t_own && t_wen)) ? 32'h0 : t_rdata;
                chk("rnd_rdata", t_own ? lsu_rdata : ifu_rdata, exp_rd);
                chk("rnd_err", t_own ? lsu_err : ifu_err, (t_d >= T));
                ntxn++;
                $display("txn %0d owner=%s addr=0x%08h wen=%0d err=%0d rdata=0x%08h",
                         ntxn, t_own ? "lsu" : "ifu", t_addr, t_wen, (t_d >= T), exp_rd);
            end
            exp_mrv = t_live && !t_acc && (cyc > t_g);
            chk("rnd_mem_req_valid", mem_req_valid, exp_mrv);
            if (exp_mrv) begin
                chk("rnd_mem_fields", {mem_addr, mem_wdata}, {t_addr, t_wdata});
                chk("rnd_mem_wen_mask", {mem_wen, mem_wmask}, {t_wen, t_wmask});
                if (mem_req_ready) begin
                    t_acc   = 1;
                    t_a     = cyc;
                    t_d     = $urandom_range(0, T);
                    t_rdata = $urandom;
                    t_done  = (t_d < T) ? t_a + 2 + t_d : t_a + 1 + T;
                end
            end
            g_i = !t_live && ifu_req_valid && (!lsu_req_valid || !ptr_lsu);
            g_l = !t_live && lsu_req_valid && (!ifu_req_valid || ptr_lsu);
            chk("rnd_ready", {ifu_req_ready, lsu_req_ready}, {g_i, g_l});
            if (g_i || g_l) begin
                t_live = 1; t_acc = 0; t_g = cyc; t_own = g_l;
                t_addr  = g_l ? lsu_addr : ifu_addr;
                t_wen   = g_l && lsu_wen;
                t_wdata = g_l ? lsu_wdata : 32'h0;
                t_wmask = (g_l && lsu_wen) ? lsu_wmask : 4'h0;
                ig = g_i; lg = g_l;
            end
        end
        chk("rnd_some_txns", (ntxn > 50), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the core's single data-memory port.
- Shares the port between instruction fetch (read-only) and the load/store unit (read or masked write).
- One transaction in flight at a time; requests are latched, issued, then completed with a registered response routed back to the owner.
- Bounded response wait with a timeout error; round-robin fairness between the two requesters.

Parameters:
- XLEN, 32, address/data width.
- TIMEOUT, 255, max cycles waiting for a memory response before an error completion (>=1).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-low reset
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted this cycle
- ifu_addr  in  XLEN  fetch address
- ifu_resp_valid  out  1  fetch completion pulse
- ifu_rdata  out  XLEN  fetch data
- ifu_err  out  1  fetch timed out (qualified by ifu_resp_valid)
- lsu_req_valid  in  1  load/store request
- lsu_req_ready  out  1  load/store accepted this cycle
- lsu_addr  in  XLEN  load/store address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  XLEN  store data
- lsu_wmask  in  4  store byte mask
- lsu_resp_valid  out  1  load/store completion pulse (also for stores)
- lsu_rdata  out  XLEN  load data (0 for stores)
- lsu_err  out  1  load/store timed out
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  XLEN  latched address
- mem_wen  out  1  latched write enable (0 for fetch)
- mem_wdata  out  XLEN  latched write data (0 for fetch)
- mem_wmask  out  4  latched mask (0 for fetch and loads)
- mem_resp_valid  in  1  memory response
- mem_rdata  in  XLEN  memory read data

Behaviour:
- Reset (rst=0, async, any state):
  - FSM to IDLE; priority pointer = LSU-first; timeout counter = 0.
  - All outputs 0; latched request registers 0.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any *_req_valid, grant per priority: pointer's side if valid, else the other side.
  - Grant is combinational: granted *_req_ready=1 in the same cycle; the other ready stays 0. Ready is never 1 outside IDLE.
  - On grant, latch addr/wen/wdata/wmask and owner; next state ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE:
  - mem_req_valid=1 with the latched fields.
  - mem_req_ready=1: go to WAIT, clear the timeout counter. Otherwise hold all fields stable.
- WAIT:
  - mem_req_valid=0; counter increments each cycle.
  - mem_resp_valid=1: register the owner's resp_valid=1, rdata=mem_rdata (lsu_rdata forced 0 for stores), err=0, for the next cycle only.
  - Else if counter reaches TIMEOUT-1: same registered completion with err=1, rdata=0.
  - Either way: next state IDLE; pointer set to the non-owner side (last granted gets lower priority).
- Completion outputs are single-cycle pulses. The cycle they are high, the FSM is in IDLE and may grant a new request.
- Minimum latency, request valid at cycle 0 with memory always ready:
  - cycle 0: accept
  - cycle 1: mem_req_valid
  - cycle 2: earliest mem_resp_valid
  - cycle 3: *_resp_valid
- mem_resp_valid in IDLE or ISSUE is ignored (no pulse, no state change).
- Both requests valid simultaneously: only one granted; the loser's valid must be held and is granted in the next IDLE.
- Requesters may drop valid before a grant without effect.
- A response arriving exactly when the counter reaches TIMEOUT-1 takes precedence: normal completion, err=0.
- Counter width is clog2(TIMEOUT)+1 and it saturates; no wrap-around.

Test Plan:
- Reset mid-WAIT, lsu store outstanding → next cycle all outputs 0, FSM IDLE; after release, ifu_req_valid with ifu_addr=0x80000000 is granted same cycle (LSU-first pointer, LSU idle).
- Single fetch, ifu_addr=0x80000004, memory ready immediately and returns 0x00000413 one cycle after accept of mem_req → mem_addr=0x80000004, mem_wen=0, mem_wmask=0; ifu_resp_valid pulses one cycle with ifu_rdata=0x00000413, ifu_err=0, 3 cycles after ifu_req_ready.
- Both valid every cycle from reset → grants alternate LSU, IFU, LSU, IFU; ready never high for both in one cycle.
- Store lsu_addr=0x80001000, wdata=0xDEADBEEF, wmask=4'b0011, mem_req_ready low for 5 cycles → mem_* fields stable across stall; lsu_resp_valid=1, lsu_rdata=0, lsu_err=0 after response.
- TIMEOUT=4, load issued, memory never responds → lsu_resp_valid with lsu_err=1, lsu_rdata=0 exactly 4 cycles after entering WAIT; a late mem_resp_valid in IDLE produces no pulse.
- TIMEOUT=4, response on the final counted cycle → err=0, data delivered.
